// File: rtl/icache_pkg.sv
// Shared types and constants for the icache burst adapter.
package icache_pkg;

   localparam int unsigned LINE_W   = 256;
   localparam int unsigned BEAT_W   = 64;
   localparam int unsigned BEATS    = LINE_W / BEAT_W;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned OFFSET_W = 5;
   localparam int unsigned CNT_W    = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } icache_adapter_state_t;

   typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'((1 << OFFSET_W) - 1);
   endfunction

endpackage

// File: rtl/icache_burst_counter.sv
// 2-bit beat counter shared by the read and write burst paths.
module icache_burst_counter
   import icache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   output logic [CNT_W-1:0] cnt,
   output logic             last_c
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (adv) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign last_c = (cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_burst_adapter.sv
// Splits 256-bit icache line transfers into 4-beat 64-bit memory bursts.
// Optional perf counters are enabled with ICACHE_ADAPTER_PERF_EN.
module icache_burst_adapter
   import icache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [LINE_W-1:0] line_i,
   output logic [LINE_W-1:0] line_o,
   input  logic [ADDR_W-1:0] address_i,
   input  logic              read_i,
   input  logic              write_i,
   output logic              resp_o,
   input  logic [BEAT_W-1:0] burst_i,
   output logic [BEAT_W-1:0] burst_o,
   output logic [ADDR_W-1:0] address_o,
   output logic              read_o,
   output logic              write_o,
   input  logic              resp_i
`ifdef ICACHE_ADAPTER_PERF_EN
   ,
   output logic [31:0]       rd_count_o,
   output logic [31:0]       wr_count_o,
   output logic [31:0]       stall_count_o
`endif
);

   icache_adapter_state_t state;
   line_t                 wr_line;
   line_t                 rd_line;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      next_cnt;
   logic                  cnt_last;
   logic                  in_burst;

   assign in_burst = (state == RD) || (state == WR);
   assign next_cnt = cnt + CNT_W'(1);
   assign line_o   = rd_line;

   icache_burst_counter u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == IDLE),
      .adv    (in_burst && resp_i),
      .cnt    (cnt),
      .last_c (cnt_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wr_line   <= '0;
         rd_line   <= '0;
         address_o <= '0;
         burst_o   <= '0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         resp_o    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Write has priority over a simultaneous read.
               if (write_i) begin
                  wr_line   <= line_i;
                  address_o <= line_align(address_i);
                  burst_o   <= line_i[BEAT_W-1:0];
                  write_o   <= 1'b1;
                  state     <= WR;
               end else if (read_i) begin
                  address_o <= line_align(address_i);
                  read_o    <= 1'b1;
                  state     <= RD;
               end
            end
            RD: begin
               if (resp_i) begin
                  rd_line[cnt] <= burst_i;
                  if (cnt_last) begin
                     read_o <= 1'b0;
                     resp_o <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            WR: begin
               if (resp_i) begin
                  burst_o <= wr_line[next_cnt];
                  if (cnt_last) begin
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               resp_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_ADAPTER_PERF_EN
   logic is_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_wr         <= 1'b0;
         rd_count_o    <= '0;
         wr_count_o    <= '0;
         stall_count_o <= '0;
      end else begin
         if (state == IDLE) is_wr <= write_i;
         if (in_burst && !resp_i) stall_count_o <= stall_count_o + 32'd1;
         if (state == DONE) begin
            if (is_wr) wr_count_o <= wr_count_o + 32'd1;
            else       rd_count_o <= rd_count_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_burst_adapter.sv
// Randomized and directed bench for icache_burst_adapter against a transaction-level model.
module tb_icache_burst_adapter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] line_i = '0;
   logic [255:0] line_o;
   logic [31:0]  address_i = '0;
   logic         read_i = 1'b0;
   logic         write_i = 1'b0;
   logic         resp_o;
   logic [63:0]  burst_i = '0;
   logic [63:0]  burst_o;
   logic [31:0]  address_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i = 1'b0;
`ifdef ICACHE_ADAPTER_PERF_EN
   logic [31:0]  rd_count_o, wr_count_o, stall_count_o;
`endif

   icache_burst_adapter dut (
      .clk       (clk),
      .rst       (rst),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
`ifdef ICACHE_ADAPTER_PERF_EN
      ,
      .rd_count_o    (rd_count_o),
      .wr_count_o    (wr_count_o),
      .stall_count_o (stall_count_o)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Transaction model: what the adapter is doing and what it has collected.
   int          m_mode;      // 0 idle, 1 read burst, 2 write burst, 3 completion cycle
   int          m_beats;
   int          m_kind;
   logic [31:0] m_addr;
   logic [63:0] m_wb [4];
   logic [63:0] m_rb [4];
   int          m_rdc, m_wrc, m_stall;

   function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endfunction

   function automatic void model_reset();
      m_mode = 0; m_beats = 0; m_kind = 0; m_addr = '0;
      m_rdc = 0; m_wrc = 0; m_stall = 0;
      for (int i = 0; i < 4; i++) begin
         m_wb[i] = '0;
         m_rb[i] = '0;
      end
   endfunction

   function automatic void model_step();
      case (m_mode)
         0: begin
            if (write_i || read_i) begin
               m_mode  = write_i ? 2 : 1;
               m_addr  = address_i & 32'hFFFF_FFE0;
               m_beats = 0;
               if (write_i)
                  for (int i = 0; i < 4; i++) m_wb[i] = line_i[64*i +: 64];
            end
         end
         1, 2: begin
            if (!resp_i) m_stall++;
            else begin
               if (m_mode == 1) m_rb[m_beats] = burst_i;
               m_beats++;
               if (m_beats == 4) begin
                  m_kind = m_mode;
                  m_mode = 3;
               end
            end
         end
         default: begin
            if (m_kind == 1) m_rdc++;
            else m_wrc++;
            m_mode = 0;
         end
      endcase
   endfunction

   function automatic void compare();
      chk("read_o", 256'(read_o), 256'(m_mode == 1));
      chk("write_o", 256'(write_o), 256'(m_mode == 2));
      chk("resp_o", 256'(resp_o), 256'(m_mode == 3));
      chk("line_o", line_o, {m_rb[3], m_rb[2], m_rb[1], m_rb[0]});
      if (m_mode == 1 || m_mode == 2) chk("address_o", 256'(address_o), 256'(m_addr));
      if (m_mode == 2) chk("burst_o", 256'(burst_o), 256'(m_wb[m_beats]));
`ifdef ICACHE_ADAPTER_PERF_EN
      chk("rd_count_o", 256'(rd_count_o), 256'(m_rdc));
      chk("wr_count_o", 256'(wr_count_o), 256'(m_wrc));
      chk("stall_count_o", 256'(stall_count_o), 256'(m_stall));
`endif
   endfunction

   // One clock: drive at negedge, model at posedge, check at next negedge.
   task automatic cyc(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [255:0] l, input logic r, input logic [63:0] b);
      read_i = rd; write_i = wr; address_i = a; line_i = l; resp_i = r; burst_i = b;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
   localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
   localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
   localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
   localparam logic [255:0] WL = {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                                  64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001};

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] rd_line;
      logic [255:0] rnd_line;
      logic [6:0]   wpat;
      logic         crd, cwr;
      logic [31:0]  ca;
      int           pulses, waitc, k;

      model_reset();
      rd_line = {B4, B3, B2, B1};
      wpat = 7'b1011001;  // LSB first: 1,0,0,1,1,0,1

      repeat (2) @(negedge clk);
      chk("reset line_o", line_o, 256'h0);
      chk("reset ctl", 256'({read_o, write_o, resp_o}), 256'h0);
      chk("reset address_o", 256'(address_o), 256'h0);
      chk("reset burst_o", 256'(burst_o), 256'h0);
`ifdef ICACHE_ADAPTER_PERF_EN
      chk("reset rd_count_o", 256'(rd_count_o), 256'h0);
`endif
      rst = 1'b0;

      // Read with back-to-back beats.
      cyc(1, 0, 32'h0000_1234, '0, 0, '0);
      chk("rd address_o literal", 256'(address_o), 256'h1220);
      chk("rd read_o literal", 256'(read_o), 256'h1);
      cyc(1, 0, 32'h0000_1234, '0, 1, B1);
      cyc(1, 0, 32'h0000_1234, '0, 1, B2);
      cyc(1, 0, 32'h0000_1234, '0, 1, B3);
      cyc(1, 0, 32'h0000_1234, '0, 1, B4);
      chk("rd resp_o literal", 256'(resp_o), 256'h1);
      chk("rd line_o literal", line_o, rd_line);
      cyc(0, 0, '0, '0, 0, '0);
      chk("rd resp_o drop", 256'(resp_o), 256'h0);

      // Write with stalls; line_i changes after the request are ignored.
      cyc(0, 1, 32'h0000_0088, WL, 0, '0);
      chk("wr burst_o beat0", 256'(burst_o), 256'(64'hDEAD_BEEF_0000_0001));
      for (int i = 0; i < 7; i++) begin
         cyc(!resp_o, 0, 32'h0000_0088, '1, wpat[i], '0);
         if (i == 3) chk("wr burst_o beat2", 256'(burst_o), 256'(64'hDEAD_BEEF_0000_0003));
      end
      chk("wr resp_o literal", 256'(resp_o), 256'h1);
      chk("wr write_o drop", 256'(write_o), 256'h0);
      chk("wr line_o kept", line_o, rd_line);
      cyc(0, 0, '0, '0, 0, '0);

      // Simultaneous read and write: write first, held read follows.
      crd = 1; cwr = 1; pulses = 0;
      for (int i = 0; i < 14; i++) begin
         cyc(crd, cwr, 32'h0000_0040, WL, 1, {32'h5A5A_0000, 32'(i)});
         if (i == 0) chk("both write first", 256'({write_o, read_o}), 256'h2);
         if (resp_o) begin
            pulses++;
            if (cwr) cwr = 0; else crd = 0;
         end
      end
      chk("both resp pulses", 256'(pulses), 256'd2);

      // Async reset mid-read after two beats.
      cyc(1, 0, 32'h0000_2000, '0, 0, '0);
      cyc(1, 0, 32'h0000_2000, '0, 1, B3);
      cyc(1, 0, 32'h0000_2000, '0, 1, B4);
      #2 rst = 1'b1;
      #1;
      chk("arst ctl", 256'({read_o, write_o, resp_o}), 256'h0);
      chk("arst line_o", line_o, 256'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      read_i = 0;
      for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 1, B1);
      cyc(1, 0, 32'h0000_3000, '0, 0, '0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(pulses == 0, 0, 32'h0000_3000, '0, 1, B2);
         if (resp_o) pulses++;
      end
      chk("arst recovery resp", 256'(pulses), 256'd1);

      // Excess resp_i during a read.
      cyc(0, 0, '0, '0, 0, '0);
      crd = 1; pulses = 0;
      cyc(crd, 0, 32'h0000_0500, '0, 0, '0);
      for (int i = 0; i < 7; i++) begin
         cyc(crd, 0, 32'h0000_0500, '0, (i < 6), {32'hC0DE_0000, 32'(i)});
         if (resp_o) begin pulses++; crd = 0; end
      end
      chk("excess resp pulses", 256'(pulses), 256'd1);
      chk("excess idle", 256'({read_o, write_o}), 256'h0);
      chk("excess line_o literal", line_o,
          {64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
           64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000});

      // Randomized traffic.
      crd = 0; cwr = 0; ca = '0; waitc = 0;
      for (int n = 0; n < 3000; n++) begin
         if (!crd && !cwr && $urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 2);
            crd = (k != 1);
            cwr = (k != 0);
            ca = $urandom;
            waitc = 0;
         end
         for (int j = 0; j < 8; j++) rnd_line[32*j +: 32] = $urandom;
         cyc(crd, cwr, ca, rnd_line, 1'($urandom_range(0, 1)), {$urandom, $urandom});
         if (crd || cwr) begin
            waitc++;
            if (resp_o) begin
               if (crd && cwr) cwr = 0;
               else begin crd = 0; cwr = 0; end
               waitc = 0;
            end else if (waitc > 200) begin
               total++; bad++;
               $display("FAIL rand timeout act=no_resp exp=resp_o");
               crd = 0; cwr = 0;
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
